// File: rtl/ov5640_pwr_seq_if.sv
// ov5640_pwr_seq_if: camera-side control and status bundle of the OV5640 power sequencer
interface ov5640_pwr_seq_if;
   logic       cam_restart;
   logic       cfg_done;
   logic       ov5640_pwdn;
   logic       ov5640_rst_n;
   logic       cfg_rst_n;
   logic       power_done;
   logic       cam_ready;
   logic       cam_err;
   logic [1:0] retry_cnt;
   modport master (
      input  cam_restart, cfg_done,
      output ov5640_pwdn, ov5640_rst_n, cfg_rst_n, power_done, cam_ready, cam_err, retry_cnt
   );
   modport slave (
      output cam_restart, cfg_done,
      input  ov5640_pwdn, ov5640_rst_n, cfg_rst_n, power_done, cam_ready, cam_err, retry_cnt
   );
endinterface

// File: rtl/ov5640_pwr_seq.sv
// ov5640_pwr_seq: OV5640 PWDN/RESETB bring-up sequencer that gates the SCCB configuration logic
// OV5640_CFG_WATCHDOG_EN builds the configuration watchdog with power-cycle retries.
module ov5640_pwr_seq #(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int T_PWDN_US      = 5000,
   parameter int T_RST_US       = 1000,
   parameter int T_INIT_US      = 20000,
   parameter int CFG_TIMEOUT_US = 100000,
   parameter int MAX_RETRY      = 3
) (
   input logic sys_clk,
   input logic sys_rst,
   ov5640_pwr_seq_if.master bus
);
   localparam int DIV = CLK_FREQ / 1_000_000;
   localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
   if (CLK_FREQ % 1_000_000 != 0 || DIV < 1) begin : g_bad_freq
      $error("CLK_FREQ must be a positive multiple of 1 MHz");
   end
   if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
      $error("MAX_RETRY must be in 0..3");
   end
   typedef enum logic [2:0] {S_PWDN, S_RST, S_INIT, S_CFG, S_READY, S_ERR} state_t;
   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [16:0]     us_q, us_d, lim;
   logic [1:0]      retry_q, retry_d;
   logic            run_q;
   logic            tick, expire, clr;
   logic            pwdn_q, pwdn_d, rst_n_q, rst_n_d, cfg_rst_n_q, cfg_rst_n_d;
   logic            power_done_q, power_done_d, cam_ready_q, cam_ready_d, cam_err_q, cam_err_d;
   always_comb begin
      tick   = pre_q == PW'(DIV - 1);
      lim    = state_q == S_PWDN ? 17'(T_PWDN_US - 1) :
               state_q == S_RST  ? 17'(T_RST_US - 1)  :
               state_q == S_INIT ? 17'(T_INIT_US - 1) : 17'(CFG_TIMEOUT_US - 1);
      // the first edge out of reset is the PWDN entry edge, so nothing expires on it
      expire = run_q && tick && us_q == lim;
      state_d = state_q;
      retry_d = retry_q;
      if (bus.cam_restart) begin
         state_d = S_PWDN;
         retry_d = '0;
      end else if (state_q == S_PWDN && expire) state_d = S_RST;
      else if (state_q == S_RST && expire) state_d = S_INIT;
      else if (state_q == S_INIT && expire) state_d = S_CFG;
      else if (state_q == S_CFG && bus.cfg_done) state_d = S_READY;
`ifdef OV5640_CFG_WATCHDOG_EN
      else if (state_q == S_CFG && expire) begin
         state_d = retry_q < 2'(MAX_RETRY) ? S_PWDN : S_ERR;
         retry_d = retry_q < 2'(MAX_RETRY) ? retry_q + 2'd1 : retry_q;
      end
`endif
   end
   always_comb begin
      clr          = !run_q || bus.cam_restart || state_d != state_q;
      pre_d        = clr || tick ? '0 : pre_q + PW'(1);
      us_d         = clr ? '0 : us_q + 17'(tick);
      pwdn_d       = state_d == S_PWDN || state_d == S_ERR;
      rst_n_d      = state_d inside {S_INIT, S_CFG, S_READY};
      cfg_rst_n_d  = state_d inside {S_CFG, S_READY};
      power_done_d = state_d inside {S_CFG, S_READY};
      cam_ready_d  = state_d == S_READY;
`ifdef OV5640_CFG_WATCHDOG_EN
      cam_err_d    = state_d == S_ERR;
`else
      cam_err_d    = 1'b0;
`endif
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_PWDN;
         pre_q        <= '0;
         us_q         <= '0;
         retry_q      <= '0;
         run_q        <= 1'b0;
         pwdn_q       <= 1'b1;
         rst_n_q      <= 1'b0;
         cfg_rst_n_q  <= 1'b0;
         power_done_q <= 1'b0;
         cam_ready_q  <= 1'b0;
         cam_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         us_q         <= us_d;
         retry_q      <= retry_d;
         run_q        <= 1'b1;
         pwdn_q       <= pwdn_d;
         rst_n_q      <= rst_n_d;
         cfg_rst_n_q  <= cfg_rst_n_d;
         power_done_q <= power_done_d;
         cam_ready_q  <= cam_ready_d;
         cam_err_q    <= cam_err_d;
      end
   end
   assign bus.ov5640_pwdn  = pwdn_q;
   assign bus.ov5640_rst_n = rst_n_q;
   assign bus.cfg_rst_n    = cfg_rst_n_q;
   assign bus.power_done   = power_done_q;
   assign bus.cam_ready    = cam_ready_q;
   assign bus.cam_err      = cam_err_q;
   assign bus.retry_cnt    = retry_q;
endmodule
